// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-FF synchroniser, 3-sample
// majority vote, holding register with VALID/RD handshake, framing and overrun
// flags. Optional parity check compiled in with macro UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Rx,
  input  logic                 RD,
  output logic [DATA_BITS-1:0] DI,
  output logic                 VALID,
  output logic                 enviando,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 PAR_ERR
);

  localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned SMP_LO = OVERSAMPLE / 2 - 1;
  localparam int unsigned SMP_MD = OVERSAMPLE / 2;
  localparam int unsigned SMP_HI = OVERSAMPLE / 2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1, rx_s2;
  logic                 armed_q;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      samp_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shift_q;

  logic tick_c, end_bit_c, vote_c, vote_val_c, last_bit_c;
  logic shift_c, par_chk_c, load_c;

  assign tick_c     = (state_q != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));
  assign end_bit_c  = tick_c && (samp_cnt == OS_W'(OVERSAMPLE - 1));
  assign vote_c     = tick_c && (samp_cnt == OS_W'(SMP_HI));
  assign vote_val_c = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
  assign last_bit_c = (bit_cnt == BIT_W'(DATA_BITS - 1));

  // Two-stage synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= Rx;
      rx_s2 <= rx_s1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rx_s2 && armed_q) state_d = ST_START;
      ST_START: begin
        if (vote_c && vote_val_c) state_d = ST_IDLE;
        else if (end_bit_c)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (end_bit_c && last_bit_c) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (end_bit_c) state_d = ST_STOP;
`endif
      ST_STOP:   if (vote_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output strobes: data shift, parity check and holding-register load
  always_comb begin
    shift_c   = 1'b0;
    par_chk_c = 1'b0;
    load_c    = 1'b0;
    case (state_q)
      ST_DATA:   shift_c   = vote_c;
      ST_PARITY: par_chk_c = vote_c;
      ST_STOP:   load_c    = vote_c;
      default:   ;
    endcase
  end

  // Start re-arm: the line must be seen high in IDLE before a new start edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                              armed_q <= 1'b0;
    else if (state_q != ST_IDLE)             armed_q <= 1'b0;
    else if (rx_s2)                          armed_q <= 1'b1;
  end

  // Baud tick divider and per-bit sample / bit counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state_q == ST_IDLE || tick_c) div_cnt <= '0;
      else                              div_cnt <= div_cnt + DIV_W'(1);

      if (state_q == ST_IDLE) samp_cnt <= '0;
      else if (tick_c)        samp_cnt <= end_bit_c ? '0 : samp_cnt + OS_W'(1);

      if (state_q != ST_DATA) bit_cnt <= '0;
      else if (end_bit_c)     bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Mid-bit samples for the majority vote and LSB-first shift register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      shift_q <= '0;
    end else begin
      if (tick_c && samp_cnt == OS_W'(SMP_LO)) samp_a <= rx_s2;
      if (tick_c && samp_cnt == OS_W'(SMP_MD)) samp_b <= rx_s2;
      if (shift_c) shift_q <= {vote_val_c, shift_q[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic par_mis_q;

  // Parity mismatch latched at the parity-bit vote
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         par_mis_q <= 1'b0;
    else if (par_chk_c) par_mis_q <= vote_val_c ^ (^shift_q) ^ PAR_SENSE;
  end

  // Parity error flag updated with each delivered word
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      PAR_ERR <= 1'b0;
    else if (load_c) PAR_ERR <= par_mis_q;
  end
`else
  assign PAR_ERR = 1'b0;
`endif

  // Holding register, handshake and status flags; a new word wins over RD
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DI        <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
      enviando  <= 1'b0;
    end else begin
      enviando <= (state_d != ST_IDLE);
      if (load_c) begin
        DI        <= shift_q;
        VALID     <= 1'b1;
        FRAME_ERR <= !vote_val_c;
        OVERRUN   <= RD ? 1'b0 : (OVERRUN | VALID);
      end else if (RD && VALID) begin
        VALID   <= 1'b0;
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param, scaled to
// 160 clocks per bit (DIV = 10, 16x oversampling).
module tb_uart_rx_param;

  localparam int unsigned CLK_FREQ   = 1_600_000;
  localparam int unsigned BAUD       = 10_000;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned PARITY_ODD = 0;
  localparam int unsigned BIT        = 160;

  logic                 CLK, RST_N, Rx, RD;
  logic [DATA_BITS-1:0] DI;
  logic                 VALID, enviando, FRAME_ERR, OVERRUN, PAR_ERR;

  int total = 0;
  int bad   = 0;

  uart_rx_param #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Rx       (Rx),
    .RD       (RD),
    .DI       (DI),
    .VALID    (VALID),
    .enviando (enviando),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN  (OVERRUN),
    .PAR_ERR  (PAR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic idle_bits(input int n);
    Rx = 1'b1;
    repeat (n * BIT) @(negedge CLK);
  endtask

  // Full frame; par_flip inverts the correct parity bit when parity is built in
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    check("busy_after_start", 32'(enviando), 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ 1'(PARITY_ODD) ^ par_flip);
`else
    if (par_flip) Rx = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic pulse_rd();
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic v,
                            input logic fe, input logic ov);
    check({tag, "_di"},   32'(DI),        32'(d));
    check({tag, "_vld"},  32'(VALID),     32'(v));
    check({tag, "_fe"},   32'(FRAME_ERR), 32'(fe));
    check({tag, "_ovr"},  32'(OVERRUN),   32'(ov));
    check({tag, "_busy"}, 32'(enviando),  32'd0);
    check({tag, "_par"},  32'(PAR_ERR),   32'd0);
  endtask

  initial begin
    Rx    = 1'b1;
    RD    = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_word("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;

    // 0x55, good stop; two idle bits after
    idle_bits(1);
    send_frame(8'h55, 1'b1, 1'b0);
    check_word("f55", 8'h55, 1'b1, 1'b0, 1'b0);
    idle_bits(2);

    // 0x9A without RD -> overrun; RD clears both
    send_frame(8'h9A, 1'b1, 1'b0);
    check_word("f9a", 8'h9A, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    pulse_rd();
    check("rd_vld", 32'(VALID), 32'd0);
    check("rd_ovr", 32'(OVERRUN), 32'd0);
    pulse_rd();
    check("rd_idle_vld", 32'(VALID), 32'd0);

    // Short low glitch in idle is rejected by the start-bit vote
    Rx = 1'b0;
    repeat (5) @(negedge CLK);
    check("glitch_busy", 32'(enviando), 32'd1);
    idle_bits(1);
    check_word("glitch", 8'h9A, 1'b0, 1'b0, 1'b0);

    // 0xA3 with stop 0 -> framing error; line held low one more bit
    send_frame(8'hA3, 1'b0, 1'b0);
    check_word("fa3", 8'hA3, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0);
    check("held_low_busy", 32'(enviando), 32'd0);
    check("held_low_vld", 32'(VALID), 32'd1);
    idle_bits(1);
    pulse_rd();

    // Next good frame clears the framing error
    send_frame(8'h01, 1'b1, 1'b0);
    check_word("f01", 8'h01, 1'b1, 1'b0, 1'b0);
    idle_bits(1);

    // Reset in the middle of data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    Rx = 1'b0;
    repeat (BIT / 2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_word("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    Rx = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    idle_bits(1);
    send_frame(8'h3C, 1'b1, 1'b0);
    check_word("f3c", 8'h3C, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    pulse_rd();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 with parity 1 is good, with parity 0 is an error
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_ok_di", 32'(DI), 32'h07);
    check("par_ok_err", 32'(PAR_ERR), 32'd0);
    idle_bits(1);
    pulse_rd();
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_bad_di", 32'(DI), 32'h07);
    check("par_bad_vld", 32'(VALID), 32'd1);
    check("par_bad_err", 32'(PAR_ERR), 32'd1);
    idle_bits(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable clock, baud, data width and oversampling; 3-sample majority vote; 2-FF input synchroniser.
- Holding register with valid/read handshake; framing and overrun flags; optional parity check.
- Sits between the board RX pin and the command/decoder logic in the same clock domain.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 9600, line rate in bit/s.
- DATA_BITS, 8, payload bits per frame (5..9), sent LSB first.
- OVERSAMPLE, 16, sample ticks per bit (8 or 16).
- PARITY_ODD, 0, parity sense when the optional feature is compiled in (0 = even, 1 = odd).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Rx  input  1  serial line, idle high, asynchronous to CLK.
- RD  input  1  one-cycle pulse; consumer has taken DI.
- DI  output  DATA_BITS  last received word, held until overwritten.
- VALID  output  1  DI holds an unread word.
- enviando  output  1  frame reception in progress (START..STOP).
- FRAME_ERR  output  1  last frame had a stop bit sampled 0.
- OVERRUN  output  1  word arrived while VALID was still 1; sticky until RD.
- PAR_ERR  output  1  parity mismatch on last frame (constant 0 without the feature).

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE, synchroniser FFs = 1, DI = 0, and all flags, VALID and enviando = 0.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (325 at defaults). A counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1. It is held at 0 in IDLE.
- Sampling: bit value is the majority of the synchronised Rx at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
- IDLE:
  - Stay while the synchronised Rx = 1.
  - On synced Rx = 0, go to START, clear the tick/bit counters and set enviando = 1.
- START:
  - Vote = 1: glitch; return to IDLE and drop enviando. No flags change.
  - Vote = 0: continue at the end of the bit (tick OVERSAMPLE-1) to DATA.
- DATA:
  - Shift the vote into a shift register, LSB first.
  - After DATA_BITS bits, go to PARITY if the feature is compiled in, else to STOP.
- PARITY: compare the vote with the computed parity, latch the mismatch, then go to STOP.
- STOP:
  - Vote at mid-bit. The next cycle: DI <= shift register, VALID <= 1, FRAME_ERR <= !vote, PAR_ERR <= latched mismatch, OVERRUN <= OVERRUN | VALID(old).
  - Return to IDLE and drop enviando.
- Early stop-bit exit: the receiver returns to IDLE at mid stop-bit, allowing up to half a bit of clock mismatch.
- Framing error: a frame with FRAME_ERR = 1 still loads DI and sets VALID.
- Latency: VALID rises 1 CLK after the last stop-bit vote sample, about 9.5 bit times + 2 sync cycles after the start edge (8N1).
- RD handling:
  - RD clears VALID and OVERRUN on the next edge.
  - RD and a new word in the same cycle: the new word wins. VALID stays 1, OVERRUN = 0.
  - RD while VALID = 0: ignored.
- Line held low after a frame error: no new start is detected until Rx has been seen high for at least 1 cycle in IDLE.
- Reset mid-frame aborts the frame with no partial DI update.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: one parity bit follows the data bits and is checked per PARITY_ODD; PAR_ERR is valid alongside VALID.
- Undefined: no PARITY state, frame is start + DATA_BITS + stop, PAR_ERR tied to 0.

Test Plan:
- Defaults, 104 us bits: idle 1 bit, then frame 0x55 (bits 1,0,1,0,1,0,1,0), stop high 2 bits -> DI = 0x55, VALID = 1, FRAME_ERR = 0, enviando low after mid stop-bit.
- Second frame 0x9A (bits 0,1,0,1,1,0,0,1) without RD -> DI = 0x9A, OVERRUN = 1. Then pulse RD -> VALID = 0, OVERRUN = 0.
- Rx low pulse of 3 us in idle -> no VALID, enviando returns to 0 within 1 bit, flags unchanged.
- Frame 0xA3 with stop bit driven 0 -> DI = 0xA3, VALID = 1, FRAME_ERR = 1. Next good frame 0x01 -> FRAME_ERR = 0.
- RST_N pulsed low at mid bit 4 of a frame -> all outputs 0 immediately; following clean frame 0x3C is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD = 0: frame 0x07 with parity 1 -> PAR_ERR = 0; the same frame with parity 0 -> PAR_ERR = 1, DI = 0x07.
